// File: rtl/gamma_lut_dual_bank.sv
// gamma_lut_dual_bank: per-channel double-buffered gamma LUT on an AXI4-Stream video path, swapped at start-of-frame
module gamma_lut_dual_bank #(
  parameter int PX_WIDTH = 10,
  parameter int CHANNELS = 3,
  parameter int CH_SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         video_i_tvalid,
  output logic                         video_i_tready,
  input  logic [CHANNELS*PX_WIDTH-1:0] video_i_tdata,
  input  logic                         video_i_tuser,
  input  logic                         video_i_tlast,
  output logic                         video_o_tvalid,
  input  logic                         video_o_tready,
  output logic [CHANNELS*PX_WIDTH-1:0] video_o_tdata,
  output logic                         video_o_tuser,
  output logic                         video_o_tlast,
  input  logic                         lut_wr_en_i,
  input  logic [CH_SEL_W-1:0]          lut_wr_chan_i,
  input  logic [PX_WIDTH-1:0]          lut_wr_addr_i,
  input  logic [PX_WIDTH-1:0]          lut_wr_data_i,
  input  logic                         lut_swap_req_i,
  input  logic                         bypass_i,
  output logic                         swap_pending_o,
  output logic                         active_bank_o
);
  localparam int DW = CHANNELS * PX_WIDTH;
  localparam int DEPTH = 1 << PX_WIDTH;
  logic en, sof_acc, do_swap, bank_now, byp_now, byp_q;
  logic s1_valid, s1_bank, s1_byp, s1_user, s1_last;
  logic [DW-1:0] s1_data;
  logic [1:0][CHANNELS-1:0][PX_WIDTH-1:0] rd;

  assign en = !video_o_tvalid || video_o_tready;
  assign video_i_tready = en;
  assign sof_acc = video_i_tvalid && en && video_i_tuser;
  assign do_swap = sof_acc && (swap_pending_o || lut_swap_req_i);
  assign bank_now = active_bank_o ^ do_swap;
  assign byp_now = sof_acc ? bypass_i : byp_q;

  // Entries hold value^index, so zero power-up block RAM reads back as the identity curve
  for (genvar b = 0; b < 2; b++) begin : g_bank
    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      logic [PX_WIDTH-1:0] mem [DEPTH];
      logic [PX_WIDTH-1:0] q;
      always_ff @(posedge clk_i) begin
        if (lut_wr_en_i && lut_wr_chan_i == CH_SEL_W'(c) && active_bank_o != 1'(b))
          mem[lut_wr_addr_i] <= lut_wr_data_i ^ lut_wr_addr_i;
        if (en) q <= mem[video_i_tdata[c*PX_WIDTH +: PX_WIDTH]];
      end
      assign rd[b][c] = q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      active_bank_o <= 1'b0;
      swap_pending_o <= 1'b0;
      byp_q <= 1'b0;
      s1_valid <= 1'b0;
      s1_bank <= 1'b0;
      s1_byp <= 1'b0;
      s1_user <= 1'b0;
      s1_last <= 1'b0;
      s1_data <= '0;
      video_o_tvalid <= 1'b0;
      video_o_tdata <= '0;
      video_o_tuser <= 1'b0;
      video_o_tlast <= 1'b0;
    end else begin
      active_bank_o <= bank_now;
      swap_pending_o <= !do_swap && (swap_pending_o || lut_swap_req_i);
      byp_q <= byp_now;
      if (en) begin
        s1_valid <= video_i_tvalid;
        s1_bank <= bank_now;
        s1_byp <= byp_now;
        s1_user <= video_i_tuser;
        s1_last <= video_i_tlast;
        s1_data <= video_i_tdata;
        video_o_tvalid <= s1_valid;
        video_o_tuser <= s1_user;
        video_o_tlast <= s1_last;
        for (int k = 0; k < CHANNELS; k++)
          video_o_tdata[k*PX_WIDTH +: PX_WIDTH] <= s1_byp ? s1_data[k*PX_WIDTH +: PX_WIDTH]
                                                          : rd[s1_bank][k] ^ s1_data[k*PX_WIDTH +: PX_WIDTH];
      end
    end
  end
endmodule

// File: tb/tb_gamma_lut_dual_bank.sv
// tb_gamma_lut_dual_bank: directed and randomized checks of the dual-bank gamma LUT against a frame-level model
module tb_gamma_lut_dual_bank;
  localparam int PW = 10;
  localparam int CH = 3;
  localparam int DW = PW * CH;

  logic clk = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk = ~clk;

  logic i_tvalid = 1'b0, i_tuser = 1'b0, i_tlast = 1'b0, o_tready = 1'b1;
  logic wr_en = 1'b0, swap_req = 1'b0, bypass = 1'b0;
  logic [DW-1:0] i_tdata = '0;
  logic [1:0] wr_chan = '0;
  logic [PW-1:0] wr_addr = '0, wr_data = '0;
  logic video_i_tready, video_o_tvalid, video_o_tuser, video_o_tlast, swap_pending_o, active_bank_o;
  logic [DW-1:0] video_o_tdata;

  gamma_lut_dual_bank #(.PX_WIDTH(PW), .CHANNELS(CH)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .video_i_tvalid(i_tvalid), .video_i_tready(video_i_tready), .video_i_tdata(i_tdata),
    .video_i_tuser(i_tuser), .video_i_tlast(i_tlast),
    .video_o_tvalid(video_o_tvalid), .video_o_tready(o_tready), .video_o_tdata(video_o_tdata),
    .video_o_tuser(video_o_tuser), .video_o_tlast(video_o_tlast),
    .lut_wr_en_i(wr_en), .lut_wr_chan_i(wr_chan), .lut_wr_addr_i(wr_addr), .lut_wr_data_i(wr_data),
    .lut_swap_req_i(swap_req), .bypass_i(bypass),
    .swap_pending_o(swap_pending_o), .active_bank_o(active_bank_o)
  );

  typedef struct {logic [DW-1:0] d; logic u; logic l; int c;} beat_t;
  beat_t sb[$];
  logic [PW-1:0] m_lut [2][CH][1<<PW];
  logic m_bank = 1'b0, m_pend = 1'b0, m_byp = 1'b0;
  logic acc_last = 1'b0, chk_lat = 1'b0;
  int checks = 0, failures = 0, cyc = 0, n_acc = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] px3(input logic [PW-1:0] v);
    return {v, v, v};
  endfunction

  function automatic logic [DW-1:0] lookup(input logic [DW-1:0] x);
    logic [DW-1:0] r;
    logic [PW-1:0] v;
    for (int c = 0; c < CH; c++) begin
      v = x[c*PW +: PW];
      r[c*PW +: PW] = m_byp ? v : m_lut[m_bank][c][v];
    end
    return r;
  endfunction

  task automatic step();
    beat_t e;
    logic pre, swapped;
    @(negedge clk);
    check("i_tready", video_i_tready, !video_o_tvalid || o_tready);
    check("active_bank", active_bank_o, m_bank);
    check("swap_pending", swap_pending_o, m_pend);
    if (sb.size() == 0) check("spurious_valid", video_o_tvalid, 0);
    else if (video_o_tvalid && o_tready) begin
      e = sb.pop_front();
      check("o_tdata", video_o_tdata, e.d);
      check("o_tuser", video_o_tuser, e.u);
      check("o_tlast", video_o_tlast, e.l);
      if (chk_lat) check("latency", cyc - e.c, 2);
    end
    pre = m_bank;
    swapped = 1'b0;
    acc_last = i_tvalid && video_i_tready;
    if (acc_last) begin
      if (i_tuser) begin
        if (m_pend || swap_req) begin
          m_bank = !m_bank;
          m_pend = 1'b0;
          swapped = 1'b1;
        end
        m_byp = bypass;
      end
      e.d = lookup(i_tdata);
      e.u = i_tuser;
      e.l = i_tlast;
      e.c = cyc;
      sb.push_back(e);
      n_acc++;
    end
    if (swap_req && !swapped) m_pend = 1'b1;
    if (wr_en && wr_chan < CH) m_lut[!pre][wr_chan][wr_addr] = wr_data;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic beat(input logic [DW-1:0] d, input logic u, input logic l);
    i_tvalid = 1'b1;
    i_tdata = d;
    i_tuser = u;
    i_tlast = l;
    step();
    i_tvalid = 1'b0;
  endtask

  task automatic wr(input int c, input int a, input int d);
    wr_en = 1'b1;
    wr_chan = 2'(c);
    wr_addr = PW'(a);
    wr_data = PW'(d);
    step();
    wr_en = 1'b0;
  endtask

  task automatic drain();
    o_tready = 1'b1;
    i_tvalid = 1'b0;
    for (int i = 0; i < 20 && sb.size() > 0; i++) step();
    step();
    check("drain_empty", sb.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    for (int b = 0; b < 2; b++)
      for (int c = 0; c < CH; c++)
        for (int a = 0; a < (1 << PW); a++) m_lut[b][c][a] = PW'(a);
    #12;
    check("rst_o_tvalid", video_o_tvalid, 0);
    check("rst_o_tdata", video_o_tdata, 0);
    check("rst_o_tuser", video_o_tuser, 0);
    check("rst_o_tlast", video_o_tlast, 0);
    check("rst_swap_pending", swap_pending_o, 0);
    check("rst_active_bank", active_bank_o, 0);
    @(posedge clk);
    #1;
    rst_i = 1'b0;

    // identity after reset, exact 2-cycle latency
    chk_lat = 1'b1;
    beat(px3(10'h000), 1'b1, 1'b0);
    beat(px3(10'h155), 1'b0, 1'b0);
    beat(px3(10'h3FF), 1'b0, 1'b1);
    drain();
    chk_lat = 1'b0;

    // inverted curve into shadow, out-of-range channel write, swap mid-frame
    for (int c = 0; c < CH; c++)
      for (int a = 0; a < (1 << PW); a++) wr(c, a, 10'h3FF - a);
    wr(3, 10'h155, 10'h000);
    beat(px3(10'h010), 1'b1, 1'b0);
    swap_req = 1'b1;
    beat(px3(10'h020), 1'b0, 1'b0);
    swap_req = 1'b0;
    beat(px3(10'h155), 1'b0, 1'b1);
    beat(px3(10'h000), 1'b1, 1'b0);
    beat(px3(10'h100), 1'b0, 1'b0);
    beat(px3(10'h155), 1'b0, 1'b1);
    drain();

    // per-channel curves in the other bank
    for (int a = 0; a < (1 << PW); a++) begin
      wr(0, a, a);
      wr(1, a, 10'h200);
      wr(2, a, a >> 1);
    end
    swap_req = 1'b1;
    step();
    swap_req = 1'b0;
    beat(px3(10'h3FF), 1'b1, 1'b0);
    beat({10'h0AA, 10'h155, 10'h2C3}, 1'b0, 1'b1);
    drain();

    // bypass raised mid-frame applies from the next SOF only
    beat(px3(10'h123), 1'b1, 1'b0);
    bypass = 1'b1;
    beat(px3(10'h234), 1'b0, 1'b1);
    beat(px3(10'h123), 1'b1, 1'b0);
    bypass = 1'b0;
    beat(px3(10'h345), 1'b0, 1'b1);
    beat(px3(10'h345), 1'b1, 1'b1);
    drain();

    // swap request coincident with SOF acceptance
    swap_req = 1'b1;
    beat(px3(10'h000), 1'b1, 1'b0);
    swap_req = 1'b0;
    beat(px3(10'h100), 1'b0, 1'b1);
    drain();

    // random backpressure
    n_acc = 0;
    for (int g = 0; g < 6000 && n_acc < 1000; g++) begin
      if (!i_tvalid || acc_last) begin
        i_tvalid = $urandom_range(0, 3) != 0;
        i_tdata = DW'($urandom);
        i_tuser = (n_acc % 64) == 0;
        i_tlast = (n_acc % 64) == 63;
      end
      o_tready = 1'($urandom_range(0, 1));
      step();
    end
    i_tvalid = 1'b0;
    check("bp_beats", n_acc, 1000);
    drain();

    // reset mid-frame with a swap pending; shadow data survives
    swap_req = 1'b1;
    beat(px3(10'h001), 1'b1, 1'b1);
    swap_req = 1'b0;
    drain();
    for (int c = 0; c < CH; c++) wr(c, 10'h055, 10'h2AA);
    swap_req = 1'b1;
    step();
    swap_req = 1'b0;
    beat(px3(10'h001), 1'b1, 1'b0);
    beat(px3(10'h002), 1'b0, 1'b0);
    #2;
    rst_i = 1'b1;
    #1;
    check("midrst_o_tvalid", video_o_tvalid, 0);
    check("midrst_swap_pending", swap_pending_o, 0);
    check("midrst_active_bank", active_bank_o, 0);
    m_bank = 1'b0;
    m_pend = 1'b0;
    m_byp = 1'b0;
    sb.delete();
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    swap_req = 1'b1;
    step();
    swap_req = 1'b0;
    beat(px3(10'h055), 1'b1, 1'b1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/gamma_lut_dual_bank.md
Name: gamma_lut_dual_bank

Overview:
- Runtime-reloadable, multi-channel gamma corrector for the AXI4-Stream video pipeline.
- Successor to the fixed single-curve ROM: each colour channel gets its own 2^PX_WIDTH-entry LUT, double-buffered as active and shadow banks.
- Host writes the shadow bank, then requests a swap; the swap takes effect only at the next start-of-frame, so a frame never mixes curves.
- Sits between the demosaic/colour stages and the video output.

Parameters:
- PX_WIDTH, 10, bits per colour component; LUT depth = 2^PX_WIDTH, LUT word = PX_WIDTH.
- CHANNELS, 3, components per pixel beat; tdata width = CHANNELS*PX_WIDTH, channel 0 in the LSBs.
- CH_SEL_W, $clog2(CHANNELS) (min 1), width of the host channel select.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  asynchronous reset, active-high
- video_i_tvalid  in  1  input beat valid
- video_i_tready  out  1  input ready
- video_i_tdata  in  CHANNELS*PX_WIDTH  input pixel
- video_i_tuser  in  1  start of frame
- video_i_tlast  in  1  end of line
- video_o_tvalid  out  1  output beat valid
- video_o_tready  in  1  downstream ready
- video_o_tdata  out  CHANNELS*PX_WIDTH  corrected pixel
- video_o_tuser  out  1  start of frame, delayed with data
- video_o_tlast  out  1  end of line, delayed with data
- lut_wr_en_i  in  1  host write strobe to the shadow bank
- lut_wr_chan_i  in  CH_SEL_W  target channel
- lut_wr_addr_i  in  PX_WIDTH  table index
- lut_wr_data_i  in  PX_WIDTH  table value
- lut_swap_req_i  in  1  one-cycle pulse requesting a bank swap at the next SOF
- bypass_i  in  1  pass data through uncorrected; sampled at SOF
- swap_pending_o  out  1  swap requested, not yet applied
- active_bank_o  out  1  bank currently used for lookup

Behaviour:
- Clock and reset: single clock domain clk_i; reset rst_i is asynchronous, active-high.
- Storage:
  - 2*CHANNELS simple dual-port RAMs, 2^PX_WIDTH x PX_WIDTH, synchronous read.
  - Contents are not reset. Initial contents are the identity map, bank 0 and bank 1.
- Reset values: video_o_tvalid=0, video_o_tdata=0, video_o_tuser=0, video_o_tlast=0, swap_pending_o=0, active_bank_o=0, internal bypass flag=0.
- Pipeline:
  - Two stages, S1 = RAM read, S2 = output register; latency exactly 2 accepted-to-valid cycles with no stall.
  - Global enable: en = !S2_valid || video_o_tready.
  - video_i_tready = en, which is combinational from video_o_tready.
  - S1_valid and S2_valid advance only when en=1. RAM read enable = en, so stalled data is held.
  - Full throughput: one beat per cycle while tready is held high.
  - tuser and tlast travel in lockstep with tdata.
- Lookup: out[c] = LUT[active][c][in[c]], independently per channel c.
  - If the bypass flag is set, out[c] = in[c], delayed by the same 2 cycles.
- Host writes:
  - When lut_wr_en_i=1, write LUT[!active_bank][lut_wr_chan_i][lut_wr_addr_i] = lut_wr_data_i.
  - lut_wr_chan_i >= CHANNELS: write ignored.
  - Writes never touch the active bank, and are accepted every cycle regardless of stall.
- Swap protocol:
  - lut_swap_req_i=1 sets swap_pending_o=1 on the next edge. Repeat requests while pending are absorbed.
  - When an input beat with tuser=1 is accepted (video_i_tvalid && video_i_tready && video_i_tuser), and the request is pending or arrives in that same cycle:
    - active_bank_o toggles and swap_pending_o clears on that edge;
    - that SOF beat and the rest of the frame use the new bank.
  - The bank select is captured per beat into S1, so beats already in flight complete with the old bank.
  - SOF accepted with no pending request: no swap.
  - Write and swap in the same cycle: the write targets the bank that was shadow before the edge. That bank becomes active, and the write still lands in it; this is the host's responsibility.
- Bypass: bypass_i is captured only on an accepted SOF beat, same timing as the swap, and is held for the whole frame.
- Reset mid-frame: outputs drop to reset values immediately; the pending swap is lost and active_bank returns to 0. RAM contents persist.

Test Plan:
- Identity after reset: feed 0x000, 0x155, 0x3FF on all 3 channels with tready=1 -> identical values out 2 cycles later, one per cycle, tuser/tlast aligned.
- Reload and swap:
  - Write inverted curve LUT[1][c][a] = 0x3FF - a for all a and c, then pulse swap mid-frame.
  - Remaining beats of the current frame are unchanged.
  - Next SOF: pixel 0x000 -> 0x3FF and 0x100 -> 0x2FF; active_bank_o = 1 and swap_pending_o = 0 from the SOF acceptance edge.
- Backpressure: random video_o_tready at 50% over 1000 beats -> no loss, no duplication, order preserved, video_i_tready low only when S2 is full and downstream is not ready.
- Per-channel: load ch0 = identity, ch1 = constant 0x200, ch2 = identity>>1 into the shadow bank, then swap -> input {0x3FF, 0x3FF, 0x3FF} gives {0x3FF, 0x200, 0x1FF}.
- Bypass and edge cases:
  - bypass_i raised mid-frame -> no effect until the next SOF, then output equals input.
  - Swap request coincident with an SOF acceptance -> swap applied on that same beat.
- Reset mid-frame with a swap pending -> video_o_tvalid = 0, swap_pending_o = 0, active_bank_o = 0 immediately; LUT data written before the reset is still readable after a subsequent swap.
